// File: rtl/tick_period_meter.sv
// Measures the interval in clk cycles between rising edges of a (possibly asynchronous) tick,
// delivering each result over valid/ready with overflow, lost-result and lock status.
module tick_period_meter #(
    parameter int MAX_PERIOD  = 65535,
    parameter int NBITS       = $clog2(MAX_PERIOD + 1),
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             tick_in,
    output logic [NBITS-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             overflow,
    output logic             lost,
    output logic             locked
);

    localparam logic [NBITS-1:0] MAX_CNT = NBITS'(MAX_PERIOD);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_d;
    logic                   tick_edge;
    logic [NBITS-1:0]       cnt;
    logic [NBITS-1:0]       prev;
    logic [NBITS:0]         diff;

    // The synchronizer keeps running while disabled so re-enabling never sees a stale edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_ff <= '0;
            sync_d  <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], tick_in};
            sync_d  <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign tick_edge = sync_ff[SYNC_STAGES-1] & ~sync_d;

    always_comb begin
        diff = '0;
        if (cnt >= prev)
            diff = {1'b0, cnt} - {1'b0, prev};
        else
            diff = {1'b0, prev} - {1'b0, cnt};
    end

    // A capture in the same cycle as a handshake wins, so period_valid stays high for the new result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            prev         <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            overflow     <= 1'b0;
            lost         <= 1'b0;
            locked       <= 1'b0;
        end else begin
            lost <= 1'b0;
            if (period_valid && period_ready)
                period_valid <= 1'b0;

            if (!enable) begin
                state        <= IDLE;
                cnt          <= '0;
                prev         <= '0;
                period_valid <= 1'b0;
                overflow     <= 1'b0;
                locked       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt   <= '0;
                        state <= ARM;
                    end
                    ARM: begin
                        if (tick_edge) begin
                            cnt   <= NBITS'(1);
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (tick_edge) begin
                            period       <= cnt;
                            period_valid <= 1'b1;
                            overflow     <= 1'b0;
                            locked       <= (diff <= (NBITS+1)'(1));
                            prev         <= cnt;
                            cnt          <= NBITS'(1);
                            lost         <= period_valid && !period_ready;
                        end else if (cnt == MAX_CNT) begin
                            overflow <= 1'b1;
                            locked   <= 1'b0;
                            cnt      <= '0;
                            prev     <= '0;
                            state    <= ARM;
                        end else begin
                            cnt <= cnt + NBITS'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
